// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
//
// Program-counter generator for the superscalar front end. Each accepted
// request produces one fetch-group address, aligned to FETCH_WIDTH
// instructions. Alongside it come a per-slot valid mask and a redirect epoch
// tag. Three redirect sources are arbitrated in fixed priority:
// trap > execute > decode.
//
// Ports
//   clk                 clock
//   rst_n               asynchronous active-low reset
//   trap_valid/addr     trap/exception redirect (highest priority)
//   ex_redirect_*       execute-stage redirect (jalr / conditional branch)
//   dec_redirect_*      decode-stage redirect (jal, lowest priority)
//   pc_ready            fetch unit accepts the current group
//   pc_valid            pc_addr / pc_slot_mask are meaningful
//   pc_addr             fetch address, bits [1:0] always zero
//   pc_slot_mask        bit i set when slot i of the group is to be executed
//   pc_epoch            redirect epoch of the current group
//   misalign_fault      an ex/dec redirect target was not word aligned
// -----------------------------------------------------------------------------
module fetch_pc_gen #(
    parameter int                XLEN         = 32,
    parameter int                FETCH_WIDTH  = 2,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                EPOCH_W      = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trap_valid,
    input  logic [XLEN-1:0]        trap_addr,
    input  logic                   ex_redirect_valid,
    input  logic [XLEN-1:0]        ex_redirect_addr,
    input  logic                   dec_redirect_valid,
    input  logic [XLEN-1:0]        dec_redirect_addr,
    input  logic                   pc_ready,
    output logic                   pc_valid,
    output logic [XLEN-1:0]        pc_addr,
    output logic [FETCH_WIDTH-1:0] pc_slot_mask,
    output logic [EPOCH_W-1:0]     pc_epoch,
    output logic                   misalign_fault
);

    localparam int OFF     = $clog2(FETCH_WIDTH);
    // Lowest address bit that changes from one fetch group to the next.
    localparam int GRP_LSB = OFF + 2;
    localparam int GRP_W   = XLEN - GRP_LSB;
    // Slot index is OFF bits wide; keep at least one bit so FETCH_WIDTH=1 works.
    localparam int SLOT_W  = (OFF == 0) ? 1 : OFF;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_addr_q, pc_addr_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic              fault_q, fault_d;

    logic [XLEN-1:0]   side_target;   // winning ex/dec target (ex beats dec)
    logic [XLEN-1:0]   pc_seq;        // next sequential group address
    logic [GRP_W-1:0]  grp_next;
    logic [EPOCH_W-1:0] epoch_inc;
    logic [SLOT_W-1:0] slot_idx;

    assign side_target = ex_redirect_valid ? ex_redirect_addr : dec_redirect_addr;
    assign grp_next    = pc_addr_q[XLEN-1:GRP_LSB] + GRP_W'(1);
    assign pc_seq      = {grp_next, {GRP_LSB{1'b0}}};
    assign epoch_inc   = epoch_q + EPOCH_W'(1);

    // Word offset inside the fetch group; zero when a group is a single slot.
    assign slot_idx = (OFF == 0) ? '0
                    : SLOT_W'((pc_addr_q >> 2) & XLEN'(FETCH_WIDTH - 1));

    // -------------------------------------------------------------------------
    // Next-state / next-PC logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        state_d   = state_q;
        pc_addr_d = pc_addr_q;
        epoch_d   = epoch_q;
        fault_d   = fault_q;

        unique case (state_q)
            FAULT: begin
                // Only a trap leaves FAULT; a misaligned trap target is
                // silently truncated.
                if (trap_valid) begin
                    pc_addr_d = {trap_addr[XLEN-1:2], 2'b00};
                    epoch_d   = epoch_inc;
                    fault_d   = 1'b0;
                    state_d   = RUN;
                end
            end

            default: begin // BOOT and RUN handle redirects identically
                if (trap_valid) begin
                    pc_addr_d = {trap_addr[XLEN-1:2], 2'b00};
                    epoch_d   = epoch_inc;
                    state_d   = RUN;
                end else if (ex_redirect_valid || dec_redirect_valid) begin
                    // The truncated target still loads and the epoch still
                    // advances even when the target faults.
                    pc_addr_d = {side_target[XLEN-1:2], 2'b00};
                    epoch_d   = epoch_inc;
                    if (side_target[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q == BOOT) begin
                    state_d = RUN;
                end else if (pc_ready) begin
                    pc_addr_d = pc_seq;
                end
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_addr_q <= RESET_VECTOR;
            epoch_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_addr_q <= pc_addr_d;
            epoch_q   <= epoch_d;
            fault_q   <= fault_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pc_valid       = (state_q == RUN);
    assign pc_addr        = pc_addr_q;
    assign pc_epoch       = epoch_q;
    assign misalign_fault = fault_q;

    // Slots below the entry offset of a redirect target are not executed.
    always_comb begin
        pc_slot_mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            pc_slot_mask[i] = pc_valid && (i >= int'(slot_idx));
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_gen
//
// Directed bench for fetch_pc_gen with FETCH_WIDTH=4, RESET_VECTOR=0 and
// EPOCH_W=3. Every step drives the inputs and pushes the output it expects
// after the next rising edge; the expectation is popped and compared 1 ns
// after that edge.
// -----------------------------------------------------------------------------
module tb_fetch_pc_gen;

    localparam int XLEN = 32;
    localparam int FW   = 4;
    localparam int EW   = 3;

    logic            clk;
    logic            rst_n;
    logic            trap_valid;
    logic [XLEN-1:0] trap_addr;
    logic            ex_redirect_valid;
    logic [XLEN-1:0] ex_redirect_addr;
    logic            dec_redirect_valid;
    logic [XLEN-1:0] dec_redirect_addr;
    logic            pc_ready;
    logic            pc_valid;
    logic [XLEN-1:0] pc_addr;
    logic [FW-1:0]   pc_slot_mask;
    logic [EW-1:0]   pc_epoch;
    logic            misalign_fault;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
        logic [FW-1:0]   mask;
        logic [EW-1:0]   epoch;
        logic            fault;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int total = 0;
    int bad   = 0;

    fetch_pc_gen #(
        .XLEN         (XLEN),
        .FETCH_WIDTH  (FW),
        .RESET_VECTOR (32'h0000_0000),
        .EPOCH_W      (EW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .trap_valid         (trap_valid),
        .trap_addr          (trap_addr),
        .ex_redirect_valid  (ex_redirect_valid),
        .ex_redirect_addr   (ex_redirect_addr),
        .dec_redirect_valid (dec_redirect_valid),
        .dec_redirect_addr  (dec_redirect_addr),
        .pc_ready           (pc_ready),
        .pc_valid           (pc_valid),
        .pc_addr            (pc_addr),
        .pc_slot_mask       (pc_slot_mask),
        .pc_epoch           (pc_epoch),
        .misalign_fault     (misalign_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic v, input logic [XLEN-1:0] a,
                            input logic [FW-1:0] m, input logic [EW-1:0] ep, input logic f);
        exp_t e;
        e.valid = v;
        e.addr  = a;
        e.mask  = m;
        e.epoch = ep;
        e.fault = f;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        exp_t  e;
        string tag;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty got=none exp=entry");
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            total++;
            assert (pc_valid === e.valid) else begin
                bad++;
                $error("FAIL %s pc_valid got=%b exp=%b", tag, pc_valid, e.valid);
            end
            total++;
            assert (pc_addr === e.addr) else begin
                bad++;
                $error("FAIL %s pc_addr got=%h exp=%h", tag, pc_addr, e.addr);
            end
            total++;
            assert (pc_slot_mask === e.mask) else begin
                bad++;
                $error("FAIL %s pc_slot_mask got=%b exp=%b", tag, pc_slot_mask, e.mask);
            end
            total++;
            assert (pc_epoch === e.epoch) else begin
                bad++;
                $error("FAIL %s pc_epoch got=%0d exp=%0d", tag, pc_epoch, e.epoch);
            end
            total++;
            assert (misalign_fault === e.fault) else begin
                bad++;
                $error("FAIL %s misalign_fault got=%b exp=%b", tag, misalign_fault, e.fault);
            end
        end
    endtask

    // Check the current (combinational/asynchronous) outputs without a clock.
    task automatic check_now(input string tag, input logic v, input logic [XLEN-1:0] a,
                             input logic [FW-1:0] m, input logic [EW-1:0] ep, input logic f);
        push_exp(tag, v, a, m, ep, f);
        #1;
        pop_check();
    endtask

    // Drive one cycle of inputs, expect the given outputs after the next edge.
    task automatic step(input logic t, input logic [XLEN-1:0] ta,
                        input logic ex, input logic [XLEN-1:0] ea,
                        input logic dc, input logic [XLEN-1:0] da,
                        input logic rdy, input string tag,
                        input logic v, input logic [XLEN-1:0] a,
                        input logic [FW-1:0] m, input logic [EW-1:0] ep, input logic f);
        trap_valid         = t;
        trap_addr          = ta;
        ex_redirect_valid  = ex;
        ex_redirect_addr   = ea;
        dec_redirect_valid = dc;
        dec_redirect_addr  = da;
        pc_ready           = rdy;
        push_exp(tag, v, a, m, ep, f);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        rst_n              = 1'b0;
        trap_valid         = 1'b0;
        trap_addr          = '0;
        ex_redirect_valid  = 1'b0;
        ex_redirect_addr   = '0;
        dec_redirect_valid = 1'b0;
        dec_redirect_addr  = '0;
        pc_ready           = 1'b1;

        // Reset and BOOT
        #12;
        check_now("reset", 1'b0, 32'h0, 4'b0000, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check_now("boot", 1'b0, 32'h0, 4'b0000, 3'd0, 1'b0);
        step(0, 0, 0, 0, 0, 0, 1, "run_g0", 1'b1, 32'h00, 4'b1111, 3'd0, 1'b0);
        step(0, 0, 0, 0, 0, 0, 1, "run_g1", 1'b1, 32'h10, 4'b1111, 3'd0, 1'b0);
        step(0, 0, 0, 0, 0, 0, 1, "run_g2", 1'b1, 32'h20, 4'b1111, 3'd0, 1'b0);

        // Execute redirect while the fetch unit is stalled
        step(0, 0, 1, 32'h108, 0, 0, 0, "ex_redir", 1'b1, 32'h108, 4'b1100, 3'd1, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0, "stall_hold", 1'b1, 32'h108, 4'b1100, 3'd1, 1'b0);
        step(0, 0, 0, 0, 0, 0, 1, "after_accept", 1'b1, 32'h110, 4'b1111, 3'd1, 1'b0);

        // Priority: trap beats ex beats dec; only one epoch step
        step(1, 32'h200, 1, 32'h300, 1, 32'h400, 1, "prio_all", 1'b1, 32'h200, 4'b1111, 3'd2, 1'b0);
        step(1, 32'h20E, 0, 0, 0, 0, 1, "trap_trunc", 1'b1, 32'h20C, 4'b1000, 3'd3, 1'b0);
        step(0, 0, 1, 32'h300, 1, 32'h400, 1, "prio_ex_dec", 1'b1, 32'h300, 4'b1111, 3'd4, 1'b0);
        step(0, 0, 0, 0, 1, 32'h404, 0, "dec_redir", 1'b1, 32'h404, 4'b1110, 3'd5, 1'b0);

        // Misaligned decode target faults; only a trap recovers
        step(0, 0, 0, 0, 1, 32'h52, 1, "dec_misalign", 1'b0, 32'h50, 4'b0000, 3'd6, 1'b1);
        step(0, 0, 1, 32'h80, 0, 0, 1, "fault_ex_ign", 1'b0, 32'h50, 4'b0000, 3'd6, 1'b1);
        step(0, 0, 0, 0, 1, 32'h90, 1, "fault_dec_ign", 1'b0, 32'h50, 4'b0000, 3'd6, 1'b1);
        step(1, 32'h1000, 0, 0, 0, 0, 0, "fault_trap", 1'b1, 32'h1000, 4'b1111, 3'd7, 1'b0);

        // Address wrap at the top of the space, epoch wrap 7 -> 0
        step(1, 32'hFFFF_FFF0, 0, 0, 0, 0, 0, "trap_top", 1'b1, 32'hFFFF_FFF0, 4'b1111, 3'd0, 1'b0);
        step(0, 0, 0, 0, 0, 0, 1, "addr_wrap", 1'b1, 32'h0, 4'b1111, 3'd0, 1'b0);

        // Nine back-to-back redirects: epoch 0 -> 1 modulo 8
        for (int k = 1; k <= 9; k++) begin
            step(0, 0, 1, 32'(k * 64), 0, 0, 0, $sformatf("epoch_wrap_%0d", k),
                 1'b1, 32'(k * 64), 4'b1111, 3'(k), 1'b0);
        end

        // Asynchronous reset mid-stream
        step(0, 0, 1, 32'h340, 0, 0, 0, "pre_reset", 1'b1, 32'h340, 4'b1111, 3'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        check_now("async_reset", 1'b0, 32'h0, 4'b0000, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check_now("reboot", 1'b0, 32'h0, 4'b0000, 3'd0, 1'b0);
        step(0, 0, 0, 0, 0, 0, 1, "rerun_g0", 1'b1, 32'h00, 4'b1111, 3'd0, 1'b0);
        step(0, 0, 0, 0, 0, 0, 1, "rerun_g1", 1'b1, 32'h10, 4'b1111, 3'd0, 1'b0);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
